// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//
// Configurable UART receiver: DBIT data bits (5..9), SB_TICK s_ticks of stop
// (16/24/32 = 1/1.5/2 stop bits), run-time parity none/even/odd. Each bit is
// decided by a 2-of-3 vote on the s = 13, 14 and 15 samples. Short low pulses
// that do not survive to mid-start are rejected. Completed frames, errored
// ones included, are delivered through a valid/ready holding register.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   rx            serial line (asynchronous to clk, idle 1)
//   s_tick        one-clk enable at 16x baud
//   par_mode      00 none, 01 even, 10 odd, 11 none; sampled at start of frame
//   rx_ready      consumer accepts the held word
//   rx_valid      holding register holds an unread word
//   dout          held word, LSB = first data bit on the line
//   parity_err    parity mismatch on the held word
//   frame_err     first stop bit voted 0 on the held word
//   break_det     held word is a break (framing error on an all-zero frame)
//   overrun       an unread word was overwritten by the held word
//   rx_done_tick  combinational one-clk pulse on the final stop s_tick
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    input  logic [1:0]      par_mode,
    input  logic            rx_ready,
    output logic            rx_valid,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun,
    output logic            rx_done_tick
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam logic [4:0] S_MID      = 5'd7;
    localparam logic [4:0] S_VOTE_A   = 5'd13;
    localparam logic [4:0] S_VOTE_B   = 5'd14;
    localparam logic [4:0] S_LAST     = 5'd15;
    localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
    localparam logic [3:0] N_LAST     = 4'(DBIT - 1);

    // Input synchroniser
    logic rx_meta_q;
    logic rx_s_q;

    // Frame FSM and datapath
    state_e           state_q,  state_d;
    logic [4:0]       s_q,      s_d;
    logic [3:0]       n_q,      n_d;
    logic [DBIT-1:0]  b_q,      b_d;
    logic             xor_q,    xor_d;
    logic             perr_q,   perr_d;
    logic             ferr_q,   ferr_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             pbit_q,   pbit_d;
    logic [1:0]       smp_q,    smp_d;
    logic             frame_done;
    logic             vote_bit;

    // Holding register
    logic             rx_valid_q,   rx_valid_d;
    logic [DBIT-1:0]  dout_q,       dout_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q,  frame_err_d;
    logic             break_det_q,  break_det_d;
    logic             overrun_q,    overrun_d;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; both flops reset to the idle line level so that
    // leaving reset never looks like a start bit.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of its inputs regardless of the
    // order in which the simulator evaluates the processes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Majority of the s = 13 and s = 14 samples and the live s = 15 sample.
    assign vote_bit = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable driven here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        xor_d      = xor_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        pbit_d     = pbit_q;
        smp_d      = smp_q;
        frame_done = 1'b0;

        // Capture the two early vote samples of any sampled bit.
        if (s_tick && (state_q inside {ST_DATA, ST_PARITY, ST_STOP})) begin
            if (s_q == S_VOTE_A) smp_d[1] = rx_s_q;
            if (s_q == S_VOTE_B) smp_d[0] = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    s_d       = '0;
                    // Parity mode is frozen for the whole frame.
                    par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
                    par_odd_d = (par_mode == 2'b10);
                    xor_d     = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    pbit_d    = 1'b0;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (rx_s_q) begin
                            state_d = ST_IDLE;  // line went back high: glitch
                        end else begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d   = '0;
                        b_d   = {vote_bit, b_q[DBIT-1:1]};
                        xor_d = xor_q ^ vote_bit;
                        if (n_q == N_LAST) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 4'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        pbit_d  = vote_bit;
                        // Expected bit is XOR(data) for even, its inverse for odd.
                        if (vote_bit != (xor_q ^ par_odd_q)) perr_d = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if ((s_q == S_LAST) && !vote_bit) ferr_d = 1'b1;
                    // With one stop bit the vote and completion share a tick,
                    // which is why completion reads ferr_d rather than ferr_q.
                    if (s_q == S_STOP_END) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_done_tick = frame_done;

    // -----------------------------------------------------------------------
    // Holding register: a completing frame always loads, even when the
    // consumer accepts the previous word on the same edge.
    // -----------------------------------------------------------------------
    always_comb begin
        rx_valid_d   = rx_valid_q;
        dout_d       = dout_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        overrun_d    = overrun_q;

        if (frame_done) begin
            rx_valid_d   = 1'b1;
            dout_d       = b_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_d;
            break_det_d  = ferr_d && (b_q == '0) && (!par_en_q || !pbit_q);
            overrun_d    = rx_valid_q && !rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            xor_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            pbit_q       <= 1'b0;
            smp_q        <= '0;
            rx_valid_q   <= 1'b0;
            dout_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            xor_q        <= xor_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            pbit_q       <= pbit_d;
            smp_q        <= smp_d;
            rx_valid_q   <= rx_valid_d;
            dout_q       <= dout_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign dout       = dout_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Two receivers: u8 (DBIT=8, SB_TICK=16) and u7 (DBIT=7, SB_TICK=32). Frames
// are built tick by tick from their logical content. For each frame the bench
// predicts the completion clock from the frame-length formula and the word and
// flags from the framing rules. A monitor steps a holding-register model every
// clock and compares all outputs. Literal checks after each frame pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

    localparam int TICK_CLKS = 4;

    typedef struct {
        int         done_cyc;
        logic [8:0] data;
        bit         perr;
        bit         ferr;
        bit         brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       rx8, rx7;
    logic [1:0] par8, par7;
    logic       rdy8 = 1'b0;
    logic       rdy7 = 1'b0;

    logic       valid8, perr8, ferr8, brk8, ovr8, done8;
    logic [7:0] dout8;
    logic       valid7, perr7, ferr7, brk7, ovr7, done7;
    logic [6:0] dout7;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    bit rdy_lvl   [2];
    int pulse_cyc [2] = '{-1, -1};

    exp_t q0[$];
    exp_t q1[$];

    bit         m_valid [2];
    bit         m_perr  [2];
    bit         m_ferr  [2];
    bit         m_brk   [2];
    bit         m_ovr   [2];
    logic [8:0] m_dout  [2];

    uart_rx_cfg #(.DBIT(8), .SB_TICK(16)) u8 (
        .clk(clk), .reset_n(reset_n), .rx(rx8), .s_tick(s_tick),
        .par_mode(par8), .rx_ready(rdy8), .rx_valid(valid8), .dout(dout8),
        .parity_err(perr8), .frame_err(ferr8), .break_det(brk8),
        .overrun(ovr8), .rx_done_tick(done8)
    );

    uart_rx_cfg #(.DBIT(7), .SB_TICK(32)) u7 (
        .clk(clk), .reset_n(reset_n), .rx(rx7), .s_tick(s_tick),
        .par_mode(par7), .rx_ready(rdy7), .rx_valid(valid7), .dout(dout7),
        .parity_err(perr7), .frame_err(ferr7), .break_det(brk7),
        .overrun(ovr7), .rx_done_tick(done7)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // s_tick: one clock high out of every TICK_CLKS, changed on falling edges.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // rx_ready: a level per receiver plus an optional one-cycle pulse.
    initial forever begin
        @(negedge clk);
        rdy8 = rdy_lvl[0] || (cyc + 1 == pulse_cyc[0]);
        rdy7 = rdy_lvl[1] || (cyc + 1 == pulse_cyc[1]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One model step for receiver d, taken two time units before a rising
    // edge: registered outputs are compared with the state after the previous
    // edge, rx_done_tick with whether the coming edge is a predicted
    // completion, then the model advances across the coming edge.
    task automatic step_model(input int d);
        logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_done, rdy;
        logic [8:0] a_dout;
        bit         due;
        exp_t       e;
        string      tag;
        due = 1'b0;
        if (d == 0) begin
            a_valid = valid8; a_dout = {1'b0, dout8}; a_perr = perr8;
            a_ferr = ferr8; a_brk = brk8; a_ovr = ovr8; a_done = done8; rdy = rdy8;
            if (q0.size() > 0 && q0[0].done_cyc == cyc + 1) begin
                due = 1'b1;
                e = q0.pop_front();
            end
            tag = "u8";
        end else begin
            a_valid = valid7; a_dout = {2'b0, dout7}; a_perr = perr7;
            a_ferr = ferr7; a_brk = brk7; a_ovr = ovr7; a_done = done7; rdy = rdy7;
            if (q1.size() > 0 && q1[0].done_cyc == cyc + 1) begin
                due = 1'b1;
                e = q1.pop_front();
            end
            tag = "u7";
        end
        if (!reset_n) begin
            m_valid[d] = 1'b0; m_perr[d] = 1'b0; m_ferr[d] = 1'b0;
            m_brk[d] = 1'b0; m_ovr[d] = 1'b0; m_dout[d] = '0;
        end
        check({tag, " rx_valid"},     a_valid, m_valid[d]);
        check({tag, " dout"},         a_dout,  m_dout[d]);
        check({tag, " parity_err"},   a_perr,  m_perr[d]);
        check({tag, " frame_err"},    a_ferr,  m_ferr[d]);
        check({tag, " break_det"},    a_brk,   m_brk[d]);
        check({tag, " overrun"},      a_ovr,   m_ovr[d]);
        check({tag, " rx_done_tick"}, a_done,  due);
        if (reset_n) begin
            if (due) begin
                m_ovr[d]   = m_valid[d] && !rdy;
                m_valid[d] = 1'b1;
                m_dout[d]  = e.data;
                m_perr[d]  = e.perr;
                m_ferr[d]  = e.ferr;
                m_brk[d]   = e.brk;
            end else if (m_valid[d] && rdy) begin
                m_valid[d] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        #3;
        for (int d = 0; d < 2; d++) step_model(d);
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx8 = v;
        else        rx7 = v;
    endtask

    // Wait for a tick edge and return on the following falling edge, so the
    // line changes just after a tick and start detection lands two clocks
    // later, one tick period before the first counted s_tick.
    task automatic sync_tick(output int c0);
        @(posedge clk);
        while (s_tick !== 1'b1) @(posedge clk);
        @(negedge clk);
        c0 = cyc;
    endtask

    // Send one frame on receiver d. glitch_bit >= 0 pulls that data bit low
    // for the one tick that is seen as the s = 14 vote sample. abort_at >= 0
    // pulses reset_n at that line tick and idles the line for the rest.
    task automatic send_frame(input int d, input logic [8:0] data, input bit par_bit,
                              input bit stop_ok, input int glitch_bit, input int abort_at,
                              input bit pulse_rdy);
        bit         line[$];
        int         nb, sb, m_ticks, c0;
        logic [1:0] pm;
        bit         has_par, odd, xr, aborted;
        logic [8:0] mask;
        exp_t       e;
        nb      = (d == 0) ? 8 : 7;
        sb      = (d == 0) ? 16 : 32;
        pm      = (d == 0) ? par8 : par7;
        has_par = (pm == 2'b01) || (pm == 2'b10);
        odd     = (pm == 2'b10);
        mask    = (9'd1 << nb) - 9'd1;
        aborted = 1'b0;

        repeat (16) line.push_back(1'b0);
        for (int i = 0; i < nb; i++)
            for (int k = 0; k < 16; k++)
                line.push_back((glitch_bit == i && k == 6) ? 1'b0 : data[i]);
        if (has_par) repeat (16) line.push_back(par_bit);
        // A bad stop is held low for 9 ticks only, so the receiver's re-arm on
        // the still-low line meets a high level at mid-start and is rejected.
        for (int k = 0; k < sb; k++) line.push_back(stop_ok || k >= 9);
        repeat (24) line.push_back(1'b1);

        xr         = ^(data & mask);
        e.data     = data & mask;
        e.perr     = has_par && (par_bit != (odd ? ~xr : xr));
        e.ferr     = !stop_ok;
        e.brk      = !stop_ok && ((data & mask) == 9'd0) && (!has_par || !par_bit);
        m_ticks    = (1 + nb + (has_par ? 1 : 0)) * 16 - 8 + sb;

        sync_tick(c0);
        e.done_cyc = c0 + TICK_CLKS * m_ticks;
        if (abort_at < 0) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (pulse_rdy) pulse_cyc[d] = e.done_cyc;
        end
        for (int k = 0; k < line.size(); k++) begin
            if (k == abort_at) begin
                reset_n = 1'b0;
                aborted = 1'b1;
            end
            set_rx(d, aborted ? 1'b1 : line[k]);
            repeat (TICK_CLKS) @(negedge clk);
            if (k == abort_at) reset_n = 1'b1;
        end
    endtask

    task automatic send_glitch(input int d, input int ticks);
        int c0;
        sync_tick(c0);
        set_rx(d, 1'b0);
        repeat (ticks * TICK_CLKS) @(negedge clk);
        set_rx(d, 1'b1);
        repeat (24 * TICK_CLKS) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        rx8        = 1'b1;
        rx7        = 1'b1;
        par8       = 2'b00;
        par7       = 2'b10;
        rdy_lvl[0] = 1'b1;
        rdy_lvl[1] = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("reset rx_valid", valid8, 1'b0);
        check("reset dout",     dout8,  8'h00);
        check("reset done",     done8,  1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // 8N1
        send_frame(0, 9'h0A5, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("8N1 dout", dout8, 8'hA5);
        check("8N1 flags", {perr8, ferr8, brk8, ovr8}, 4'b0000);

        // 8E1: 0x07 has odd weight, so even parity needs a 1
        par8 = 2'b01;
        send_frame(0, 9'h007, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("8E1 bad parity", perr8, 1'b1);
        send_frame(0, 9'h007, 1'b1, 1'b1, -1, -1, 1'b0);
        #3;
        check("8E1 good parity", perr8, 1'b0);
        check("8E1 dout", dout8, 8'h07);

        // Mode 11 carries no parity bit
        par8 = 2'b11;
        send_frame(0, 9'h096, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("mode11 dout", dout8, 8'h96);

        // Framing error and break
        par8 = 2'b00;
        send_frame(0, 9'h03C, 1'b0, 1'b0, -1, -1, 1'b0);
        #3;
        check("ferr 0x3C", {ferr8, brk8}, 2'b10);
        send_frame(0, 9'h000, 1'b0, 1'b0, -1, -1, 1'b0);
        #3;
        check("break 0x00", {ferr8, brk8}, 2'b11);
        // With even parity, a parity bit of 1 on zero data is not a break
        par8 = 2'b01;
        send_frame(0, 9'h000, 1'b1, 1'b0, -1, -1, 1'b0);
        #3;
        check("no break par1", {perr8, ferr8, brk8}, 3'b110);

        // Single low sample inside a 1 data bit is out-voted
        par8 = 2'b00;
        send_frame(0, 9'h0F0, 1'b0, 1'b1, 5, -1, 1'b0);
        #3;
        check("vote glitch", dout8, 8'hF0);

        // Overrun, then accept and load on the same edge
        rdy_lvl[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("first unread ovr", ovr8, 1'b0);
        send_frame(0, 9'h022, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("overrun word", {valid8, ovr8, dout8}, {2'b11, 8'h22});
        send_frame(0, 9'h033, 1'b0, 1'b1, -1, -1, 1'b1);
        #3;
        check("same-cycle accept", {valid8, ovr8, dout8}, {2'b10, 8'h33});

        // Reset mid-DATA: held word is dropped, frame aborted
        send_frame(0, 9'h0F0, 1'b0, 1'b1, -1, 56, 1'b0);
        #3;
        check("abort outputs", {valid8, ovr8, dout8}, {2'b00, 8'h00});
        rdy_lvl[0] = 1'b1;
        send_frame(0, 9'h05A, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("after abort dout", dout8, 8'h5A);

        // 7O2: rejected 4-tick glitch, then 0x55 (even weight, odd parity 1)
        send_glitch(1, 4);
        #3;
        check("glitch no word", valid7, 1'b0);
        send_frame(1, 9'h055, 1'b1, 1'b1, -1, -1, 1'b0);
        #3;
        check("7O2 dout", dout7, 7'h55);
        check("7O2 flags", {perr7, ferr7, brk7, ovr7}, 4'b0000);
        send_frame(1, 9'h055, 1'b0, 1'b1, -1, -1, 1'b0);
        #3;
        check("7O2 bad parity", perr7, 1'b1);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable UART receiver that generalises the fixed 8-bit parity receiver. It supports compile-time data width and stop length, and a run-time parity mode of none, even or odd. It adds majority-vote bit sampling, false-start rejection, and framing, parity, break and overrun detection. The block sits between the 16x baud-tick generator and the consumer (FIFO or bus interface), and delivers each word through a valid/ready holding register.

## Interface
- DBIT, 8: data bits per frame, legal range 5–9.
- SB_TICK, 16: stop length in s_ticks; 16, 24 or 32 gives 1, 1.5 or 2 stop bits.
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk; idle level is 1.
- s_tick  input  1  one-clk enable pulse at 16x the baud rate.
- par_mode  input  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
- rx_ready  input  1  consumer accepts the held word.
- rx_valid  output  1  holding register contains an unread word.
- dout  output  DBIT  received word, LSB = first data bit received.
- parity_err  output  1  parity mismatch on the held word.
- frame_err  output  1  stop bit sampled as 0 on the held word.
- break_det  output  1  held word is a break.
- overrun  output  1  the previous unread word was overwritten by this one.
- rx_done_tick  output  1  one-clk pulse per completed frame.

## Operation
- **Input synchroniser:** rx passes through 2 flops (reset value 1). All logic below uses the synchronised value, rx_s.
- **Bit vote:** in each data, parity or first-stop bit, rx_s is sampled on the s_ticks where s = 13, 14 and 15. The bit value is the majority of these 3 samples.
- **s counter:** 5 bits wide, reset to 0 on every bit boundary.
- **IDLE:** on rx_s = 0, go to START, clear s, and latch par_mode into an internal register. A par_mode change mid-frame has no effect.
- **START:** count s_ticks. On the s_tick with s = 7:
  - rx_s = 1: return to IDLE (glitch rejected, no outputs).
  - rx_s = 0: go to DATA, with s = 0 and n = 0.
- **DATA:**
  - On the s_tick with s = 15, shift the voted bit into the MSB of a DBIT-wide shift register (right shift) and fold it into a running XOR.
  - After bit n = DBIT−1, go to PARITY if the latched mode is even or odd, else go to STOP.
- **PARITY:** on the s_tick with s = 15, compare the voted bit to the expected value.
  - Expected value is XOR(data) for even, ~XOR(data) for odd.
  - A mismatch sets the internal perr.
  - Go to STOP.
- **STOP:**
  - The voted value at s = 15 is the stop sample; stop = 0 sets the internal ferr.
  - On the s_tick with s = SB_TICK−1, the frame completes and the FSM returns to IDLE.
- **Break:** a break is ferr = 1 with all data bits 0 and, when parity is enabled, a parity bit of 0.
- **Holding register:** on frame completion, load dout, parity_err, frame_err and break_det, and set rx_valid = 1.
  - If rx_valid was 1 and was not accepted in that same cycle, overrun = 1; otherwise overrun = 0.
- **Accept:** rx_valid & rx_ready clears rx_valid. dout and the flags keep their values until the next load.
- **Accept and load in the same cycle:** the load wins. rx_valid stays 1 and overrun = 0.
- **Errored frames:** these are still delivered. Error frames never suppress rx_valid.

## Timing
- **Reset:** state IDLE, all counters and the shift register 0, every output 0, synchroniser flops 1. Reset mid-frame aborts the frame with no rx_done_tick and no load.
- **rx_done_tick:** combinational. It is high in exactly the clk cycle carrying the final STOP s_tick.
- **Load timing:** rx_valid, dout and the flags update on that same clock edge, so they are visible the following cycle.
- **Input latency:** 2 clk from rx to rx_s. Start detection adds 8 s_ticks to reach mid-start.
- **Frame length:** (1 + DBIT + P)·16 − 8 + SB_TICK s_ticks from start detection to completion, where P = 1 if parity is enabled.
- **Re-arm:** the FSM re-arms in IDLE on the cycle after completion. A start bit that immediately follows a stop is therefore detected.
- **s_tick:** if absent, all counters hold.
- **rx_ready:** ignored while rx_valid = 0.

## Test plan
- **8N1 receive:** DBIT=8, par_mode=00, send 0xA5 at 16 ticks/bit, rx_ready=1 → one rx_done_tick, dout=0xA5, all flags 0.
- **8E1 parity error:** par_mode=01, send 0x07 with parity bit 0 → parity_err=1. Resend with parity bit 1 → parity_err=0.
- **7O2, false start:** DBIT=7, SB_TICK=32, par_mode=10. Send a 4-tick low glitch, then 0x55 with parity 1 → no output for the glitch, then dout=0x55 and all flags 0.
- **Framing error and break:**
  - 8N1, data 0x3C with stop bit 0 → frame_err=1, break_det=0.
  - All-zero data with stop bit 0 → frame_err=1, break_det=1.
- **Overrun and same-cycle accept:**
  - Hold rx_ready=0 and send 0x11 then 0x22 → second word dout=0x22, overrun=1, rx_valid=1.
  - Assert rx_ready in the completion cycle of the next frame (0x33) → rx_valid stays 1, dout=0x33, overrun=0.
- **Majority vote and reset:**
  - Inject a single-sample low glitch at s=14 of a 1 data bit → bit still read as 1.
  - Assert reset_n=0 mid-DATA → all outputs 0 immediately, FSM in IDLE, no rx_done_tick.
